// File: rtl/verifier_coeff_loader.sv
// Coefficient loader feeding the Verifier's Horner evaluator.
// Streams field elements in, range-checks them, then launches one evaluation.
`ifndef F_NBITS
`define F_NBITS 64
`endif
`ifndef F_Q
`define F_Q 64'hFFFF_FFFF_0000_0001
`endif

module verifier_coeff_loader #(
  parameter int maxDegree = 8,
  parameter int cBits = $clog2(maxDegree + 1)
) (
  input  logic                                 clk,
  input  logic                                 rstb,
  input  logic                                 load,
  input  logic                                 cubic,
  input  logic                                 round,
  input  logic [cBits-1:0]                     ncoeff,
  input  logic                                 in_valid,
  input  logic [`F_NBITS-1:0]                  in_data,
  output logic                                 in_ready,
  output logic [maxDegree:0][`F_NBITS-1:0]     c_out,
  output logic                                 horner_en,
  input  logic                                 horner_ready,
  output logic                                 done,
  output logic                                 busy,
  output logic                                 range_err
);

  if (maxDegree < 3) begin : g_chk_deg
    $error("maxDegree must be at least 3");
  end
  if (cBits != $clog2(maxDegree + 1)) begin : g_chk_cbits
    $error("cBits is derived from maxDegree");
  end

  localparam logic [cBits-1:0] MaxIdx = cBits'(maxDegree);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FIRE,
    WAIT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [cBits-1:0] count_q;
  logic [cBits-1:0] target_q;
  logic             first_q;
  logic             done_q;
  logic             take;
  logic             finish;
  logic             bad_beat;
  logic             err_now;

  assign bad_beat = in_data >= `F_Q;
  assign err_now  = range_err | bad_beat;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) state_d = FILL;
      end
      FILL: begin
        if (in_valid) begin
          take = 1'b1;
          if (count_q == target_q) begin
            // A bad batch never reaches the evaluator.
            state_d = err_now ? IDLE : FIRE;
            finish  = err_now;
          end
        end
      end
      FIRE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!first_q && horner_ready) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      // Evaluator's ready may lag its enable by a cycle.
      first_q <= (state_q == FIRE);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      c_out     <= '0;
      count_q   <= '0;
      target_q  <= '0;
      range_err <= 1'b0;
    end else if (state_q == IDLE && load) begin
      c_out     <= '0;
      count_q   <= '0;
      range_err <= 1'b0;
      if (round)
        target_q <= cubic ? cBits'(3) : cBits'(2);
      else
        target_q <= (ncoeff > MaxIdx) ? MaxIdx : ncoeff;
    end else if (take) begin
      c_out[count_q] <= in_data;
      if (bad_beat) range_err <= 1'b1;
      if (count_q != target_q) count_q <= count_q + 1'b1;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign horner_en = (state_q == FIRE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_verifier_coeff_loader.sv
// Bench for verifier_coeff_loader: timestamp-based batch model,
// per-cycle compare, and directed batches with literal expectations.
`ifndef F_NBITS
`define F_NBITS 64
`endif
`ifndef F_Q
`define F_Q 64'hFFFF_FFFF_0000_0001
`endif

module tb_verifier_coeff_loader;
  localparam int NB   = `F_NBITS;
  localparam int MAXD = 8;

  logic                     clk = 1'b0;
  logic                     rstb = 1'b0;
  logic                     load = 1'b0;
  logic                     cubic = 1'b0;
  logic                     round = 1'b0;
  logic [3:0]               ncoeff = '0;
  logic                     in_valid = 1'b0;
  logic [NB-1:0]            in_data = '0;
  logic                     horner_ready = 1'b0;
  logic                     in_ready;
  logic [MAXD:0][NB-1:0]    c_out;
  logic                     horner_en;
  logic                     done;
  logic                     busy;
  logic                     range_err;

  verifier_coeff_loader #(.maxDegree(MAXD)) dut (
    .clk(clk),
    .rstb(rstb),
    .load(load),
    .cubic(cubic),
    .round(round),
    .ncoeff(ncoeff),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .c_out(c_out),
    .horner_en(horner_en),
    .horner_ready(horner_ready),
    .done(done),
    .busy(busy),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // model state
  logic [MAXD:0][NB-1:0] exp_c = '0;
  bit m_busy = 0, m_fill = 0, m_err = 0;
  bit exp_en = 0, exp_done = 0;
  int m_got = 0, m_tgt = 0;
  int m_en = -1, m_end = -1, m_from = -1;

  // monitors
  int en_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int en_cyc = -1, ld_cyc = 0, dn_cyc = 0, r_cyc = 0;
  int e0, d0, a0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input bit r, input bit cu, input logic [3:0] n);
    round = r; cubic = cu; ncoeff = n; load = 1'b1;
    ld_cyc = cyc;
    step();
    load = 1'b0;
  endtask

  task automatic send(input logic [NB-1:0] d);
    int b = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && b < 40) begin
      step();
      b++;
    end
    chk("send_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int b = 0;
    while (!done && b < lim) begin
      step();
      b++;
    end
    chk("done_seen", done, 1);
    dn_cyc = cyc;
    step();
  endtask

  initial begin
    fork
      forever begin : model
        @(posedge clk);
        if (!rstb) begin
          m_busy = 0; m_fill = 0; m_err = 0; m_got = 0; m_tgt = 0;
          m_en = -1; m_end = -1; m_from = -1; exp_c = '0;
        end else if (!m_busy && load) begin
          m_busy = 1; m_fill = 1; m_err = 0; m_got = 0; exp_c = '0;
          if (round) m_tgt = cubic ? 3 : 2;
          else m_tgt = (int'(ncoeff) > MAXD) ? MAXD : int'(ncoeff);
        end else if (m_fill && in_valid) begin
          exp_c[m_got] = in_data;
          if (in_data >= `F_Q) m_err = 1;
          m_got++;
          if (m_got == m_tgt + 1) begin
            m_fill = 0;
            if (m_err) m_end = cyc + 1;
            else begin
              m_en = cyc + 1;
              m_from = cyc + 3;
            end
          end
        end else if (m_from >= 0 && cyc >= m_from && horner_ready) begin
          m_end = cyc + 1;
          m_from = -1;
        end
        cyc++;
        exp_en = (cyc == m_en);
        exp_done = (cyc == m_end);
        if (exp_done) begin
          m_busy = 0;
          m_end = -1;
        end
      end
      forever begin : compare
        @(negedge clk);
        if (!rstb) begin
          chk("rst_in_ready", in_ready, 0);
          chk("rst_horner_en", horner_en, 0);
          chk("rst_done", done, 0);
          chk("rst_busy", busy, 0);
          chk("rst_range_err", range_err, 0);
          for (int i = 0; i <= MAXD; i++)
            chk($sformatf("rst_c_out[%0d]", i), c_out[i], 0);
        end else begin
          chk("in_ready", in_ready, m_fill);
          chk("horner_en", horner_en, exp_en);
          chk("done", done, exp_done);
          chk("busy", busy, m_busy);
          chk("range_err", range_err, m_err);
          for (int i = 0; i <= MAXD; i++)
            chk($sformatf("c_out[%0d]", i), c_out[i], exp_c[i]);
          if (horner_en) begin
            en_cnt++;
            en_cyc = cyc;
          end
          if (done) done_cnt++;
          if (in_ready && in_valid) acc_cnt++;
        end
      end
    join_none

    // reset state
    repeat (2) step();
    chk("r_busy", busy, 0);
    chk("r_in_ready", in_ready, 0);
    chk("r_c_out0", c_out[0], 0);
    rstb = 1'b1;
    step();

    // quadratic round, ready held low 6 cycles
    e0 = en_cnt; d0 = done_cnt;
    do_load(1, 0, 0);
    send(5); send(7); send(9);
    repeat (6) step();
    horner_ready = 1'b1;
    r_cyc = cyc;
    wait_done(20);
    horner_ready = 1'b0;
    chk("q_c0", c_out[0], 5);
    chk("q_c1", c_out[1], 7);
    chk("q_c2", c_out[2], 9);
    chk("q_c3", c_out[3], 0);
    chk("q_en_lat", en_cyc - ld_cyc, 4);
    chk("q_en_cnt", en_cnt - e0, 1);
    chk("q_done_lat", dn_cyc - r_cyc, 1);
    chk("q_done_cnt", done_cnt - d0, 1);
    chk("q_busy", busy, 0);

    // range error: 0, F_Q, 1
    e0 = en_cnt;
    do_load(1, 0, 0);
    send(0); send(`F_Q); send(1);
    chk("re_done", done, 1);
    chk("re_flag", range_err, 1);
    chk("re_busy", busy, 0);
    chk("re_c1", c_out[1], `F_Q);
    step();
    chk("re_sticky", range_err, 1);
    chk("re_no_en", en_cnt - e0, 0);

    // cubic round with bubbles; the load clears range_err
    do_load(1, 1, 0);
    chk("cb_clr", range_err, 0);
    a0 = acc_cnt; e0 = en_cnt;
    send(1); step(); send(2); step(); send(3); step(); send(4);
    horner_ready = 1'b1;
    wait_done(20);
    horner_ready = 1'b0;
    chk("cb_acc", acc_cnt - a0, 4);
    chk("cb_c0", c_out[0], 1);
    chk("cb_c3", c_out[3], 4);
    chk("cb_c4", c_out[4], 0);
    chk("cb_en", en_cnt - e0, 1);

    // layer clamp: ncoeff=15 on maxDegree=8
    a0 = acc_cnt;
    do_load(0, 0, 15);
    for (int v = 10; v <= 18; v++) send(NB'(v));
    in_valid = 1'b1;
    in_data = 19;
    chk("lc_no_ready", in_ready, 0);
    step(); step();
    in_valid = 1'b0;
    chk("lc_acc", acc_cnt - a0, 9);
    chk("lc_c0", c_out[0], 10);
    chk("lc_c8", c_out[8], 18);
    horner_ready = 1'b1;
    wait_done(20);
    horner_ready = 1'b0;

    // reset mid-FILL
    do_load(1, 1, 0);
    send(11); send(22);
    #2;
    rstb = 1'b0;
    #1;
    chk("rm_busy", busy, 0);
    chk("rm_in_ready", in_ready, 0);
    chk("rm_c0", c_out[0], 0);
    chk("rm_c1", c_out[1], 0);
    chk("rm_done", done, 0);
    step();
    rstb = 1'b1;
    step();
    d0 = done_cnt;
    do_load(1, 0, 0);
    send(7); send(8); send(9);
    horner_ready = 1'b1;
    wait_done(20);
    horner_ready = 1'b0;
    chk("rm_c2", c_out[2], 9);
    chk("rm_done_cnt", done_cnt - d0, 1);

    // load during WAIT is ignored
    d0 = done_cnt;
    do_load(1, 0, 0);
    send(1); send(2); send(3);
    step(); step();
    round = 1'b0; ncoeff = 8; load = 1'b1;
    step();
    load = 1'b0;
    chk("lw_busy", busy, 1);
    chk("lw_c0", c_out[0], 1);
    chk("lw_c2", c_out[2], 3);
    chk("lw_c3", c_out[3], 0);
    horner_ready = 1'b1;
    wait_done(20);
    horner_ready = 1'b0;
    repeat (4) step();
    chk("lw_done_cnt", done_cnt - d0, 1);
    chk("lw_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
